// File: rtl/ammrv_pipe_bridge.sv
// Avalon-MM pipeline bridge for the clk_2x domain: 2-entry command skid buffer, read credit cap,
// optional response register selected by `define AMMRV_PIPE_RSP_REG_EN.
module ammrv_pipe_bridge #(
  parameter int P_MAX_PENDING = 4,
  parameter int P_AW          = 32,
  localparam int PW           = $clog2(P_MAX_PENDING + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [P_AW-1:0] s_address,
  input  logic [3:0]      s_byteenable,
  input  logic [31:0]     s_writedata,
  input  logic            s_read,
  input  logic            s_write,
  output logic            s_waitrequest,
  output logic [31:0]     s_readdata,
  output logic            s_readdatavalid,
  output logic [P_AW-1:0] m_address,
  output logic [3:0]      m_byteenable,
  output logic [31:0]     m_writedata,
  output logic            m_read,
  output logic            m_write,
  input  logic            m_waitrequest,
  input  logic [31:0]     m_readdata,
  input  logic            m_readdatavalid,
  output logic [1:0]      dbg_state,
  output logic [PW-1:0]   dbg_pend_cnt
);

  // Handshake: a command moves on any edge where (read|write) is high and waitrequest is low;
  // the requester holds the command stable until then. Responses carry no backpressure.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [P_AW-1:0] addr;
    logic [3:0]      be;
    logic [31:0]     data;
    logic            rd;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          main_q, main_d, skid_q, skid_d, s_cmd;
  logic [PW-1:0] pend_q, pend_d;
  logic          s_acc, m_acc, rd_acc, rsp_dec;

  // A simultaneous read+write request is treated as a read; the write is dropped.
  assign s_cmd   = '{addr: s_address, be: s_byteenable, data: s_writedata, rd: s_read};
  assign s_acc   = (s_read | s_write) & ~s_waitrequest;
  assign m_acc   = (m_read | m_write) & ~m_waitrequest;
  assign rd_acc  = m_read & ~m_waitrequest;
  assign rsp_dec = m_readdatavalid & (pend_q != '0);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    pend_d  = pend_q + PW'(rd_acc) - PW'(rsp_dec);
    case (state_q)
      ST_EMPTY: begin
        if (s_acc) begin
          main_d  = s_cmd;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (s_acc && m_acc) begin
          main_d = s_cmd;
        end else if (s_acc) begin
          skid_d  = s_cmd;
          state_d = ST_TWO;
        end else if (m_acc) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (m_acc) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // m_read is computed from next-cycle credit so a read in main is never issued at the cap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      pend_q        <= '0;
      m_read        <= 1'b0;
      m_write       <= 1'b0;
      s_waitrequest <= 1'b1;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      pend_q        <= pend_d;
      m_read        <= (state_d != ST_EMPTY) & main_d.rd & (pend_d != PW'(P_MAX_PENDING));
      m_write       <= (state_d != ST_EMPTY) & ~main_d.rd;
      s_waitrequest <= (state_d == ST_TWO);
    end
  end

  assign m_address    = main_q.addr;
  assign m_byteenable = main_q.be;
  assign m_writedata  = main_q.data;
  assign dbg_state    = state_q;
  assign dbg_pend_cnt = pend_q;

`ifdef AMMRV_PIPE_RSP_REG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= m_readdatavalid;
      s_readdata      <= m_readdata;
    end
  end
`else
  assign s_readdatavalid = m_readdatavalid;
  assign s_readdata      = m_readdata;
`endif

endmodule
